// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial bit-sequence detector with saturating match counter
// Ports: clk_i clock; rst_ni async active-low reset; inp_valid_i/inp_bit_i qualified serial input;
//   cfg_load_i strobe latching cfg_pattern_i (bit [len-1] first), cfg_len_i, cfg_overlap_i;
//   clr_count_i sync count clear; seq_seen_o 1-cycle match pulse; match_count_o saturating count;
//   cfg_err_o active config illegal, detection disabled.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'h0B,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  parameter int                 LEN_W       = $clog2(MAX_LEN+1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               inp_valid_i,
  input  logic               inp_bit_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               clr_count_i,
  output logic               seq_seen_o,
  output logic [CNT_W-1:0]   match_count_o,
  output logic               cfg_err_o
);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d, hist_n, mask;
  logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d, fill_n;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovl_q, ovl_d, err_q, err_d, seen_q, samp, match;
  // A config load cycle swallows the input bit, so it never counts as a sample.
  // mask keeps the low len bits; a shift by MAX_LEN yields an all-ones mask.
  always_comb begin
    samp   = inp_valid_i & ~cfg_load_i;
    hist_n = {hist_q[MAX_LEN-2:0], inp_bit_i};
    fill_n = (fill_q == MAX_L) ? fill_q : fill_q + LEN_W'(1);
    mask   = ~({MAX_LEN{1'b1}} << len_q);
    match  = samp & ~err_q & (((hist_n ^ pat_q) & mask) == '0) & (fill_n >= len_q);
    hist_d = samp ? hist_n : hist_q;
    fill_d = cfg_load_i ? '0 : samp ? ((match & ~ovl_q) ? '0 : fill_n) : fill_q;
    pat_d  = cfg_load_i ? cfg_pattern_i : pat_q;
    len_d  = cfg_load_i ? cfg_len_i : len_q;
    ovl_d  = cfg_load_i ? cfg_overlap_i : ovl_q;
    err_d  = cfg_load_i ? (cfg_len_i == '0 || cfg_len_i > MAX_L) : err_q;
    cnt_d  = clr_count_i ? '0 : (match & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= DEF_OVERLAP;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      seen_q <= match;
    end
  assign seq_seen_o    = seen_q;
  assign match_count_o = cnt_q;
  assign cfg_err_o     = err_q;
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed bench with queue-based reference model for seq_detect_prog
module tb_seq_detect_prog;
  logic       clk = 0, rst_ni = 0, inp_valid_i = 0, inp_bit_i = 0, cfg_load_i = 0;
  logic       cfg_overlap_i = 0, clr_count_i = 0;
  logic [7:0] cfg_pattern_i = 0;
  logic [3:0] cfg_len_i = 0;
  logic       seen1, err1, seen2, err2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  int n_cmp = 0, n_bad = 0, pulses = 0, p0;
  always #5 clk = ~clk;
  seq_detect_prog u1 (
    .clk_i(clk), .rst_ni(rst_ni), .inp_valid_i(inp_valid_i), .inp_bit_i(inp_bit_i),
    .cfg_load_i(cfg_load_i), .cfg_pattern_i(cfg_pattern_i), .cfg_len_i(cfg_len_i),
    .cfg_overlap_i(cfg_overlap_i), .clr_count_i(clr_count_i),
    .seq_seen_o(seen1), .match_count_o(cnt1), .cfg_err_o(err1));
  seq_detect_prog #(.CNT_W(2)) u2 (
    .clk_i(clk), .rst_ni(rst_ni), .inp_valid_i(inp_valid_i), .inp_bit_i(inp_bit_i),
    .cfg_load_i(cfg_load_i), .cfg_pattern_i(cfg_pattern_i), .cfg_len_i(cfg_len_i),
    .cfg_overlap_i(cfg_overlap_i), .clr_count_i(clr_count_i),
    .seq_seen_o(seen2), .match_count_o(cnt2), .cfg_err_o(err2));
  // Reference model: the bits received since the last history clear, newest at the back.
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len, e_cnt1, e_cnt2;
  bit         m_ovl, m_err, e_seen, hit;
  function automatic bit tail_matches();
    if (q.size() < m_len) return 0;
    for (int i = 0; i < m_len; i++)
      if (q[q.size()-m_len+i] != m_pat[m_len-1-i]) return 0;
    return 1;
  endfunction
  always @(posedge clk or negedge rst_ni)
    if (!rst_ni) begin
      q.delete(); m_pat = 8'h0B; m_len = 4; m_ovl = 1; m_err = 0;
      e_seen = 0; e_cnt1 = 0; e_cnt2 = 0;
    end else begin
      hit = 0;
      if (cfg_load_i) begin
        q.delete(); m_pat = cfg_pattern_i; m_len = cfg_len_i; m_ovl = cfg_overlap_i;
        m_err = (m_len < 1 || m_len > 8);
      end else if (inp_valid_i) begin
        q.push_back(inp_bit_i);
        if (q.size() > 8) void'(q.pop_front());
        hit = !m_err && tail_matches();
        if (hit && !m_ovl) q.delete();
      end
      e_seen = hit;
      e_cnt1 = clr_count_i ? 0 : (hit && e_cnt1 < 255) ? e_cnt1 + 1 : e_cnt1;
      e_cnt2 = clr_count_i ? 0 : (hit && e_cnt2 < 3) ? e_cnt2 + 1 : e_cnt2;
    end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic compare();
    if (!rst_ni) begin
      chk("rst_seen", {seen1, seen2}, 0);
      chk("rst_cnt", {cnt1, cnt2}, 0);
      chk("rst_err", {err1, err2}, 0);
    end else begin
      chk("seen", seen1, e_seen);
      chk("cnt", cnt1, e_cnt1);
      chk("err", err1, m_err);
      chk("seen_w2", seen2, e_seen);
      chk("cnt_w2", cnt2, e_cnt2);
      chk("err_w2", err2, m_err);
      pulses += seen1;
    end
  endtask
  task automatic tick(input logic v, input logic b);
    @(negedge clk);
    compare();
    inp_valid_i = v; inp_bit_i = b; cfg_load_i = 0; clr_count_i = 0;
  endtask
  task automatic seq(input string s);
    for (int i = 0; i < s.len(); i++) tick(s[i] != "-", s[i] == "1");
    tick(0, 0);
  endtask
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    tick(1, 1);
    cfg_load_i = 1; cfg_pattern_i = p; cfg_len_i = l; cfg_overlap_i = o;
  endtask
  task automatic do_reset();
    tick(0, 0);
    rst_ni = 0;
    tick(0, 0);
    rst_ni = 1;
  endtask
  initial begin
    do_reset();
    chk("reset_cnt", cnt1, 0);
    chk("reset_err", err1, 0);
    p0 = pulses; seq("1011011");
    chk("t1_pulses", pulses - p0, 2);
    chk("t1_cnt", cnt1, 2);
    do_reset();
    cfg(8'h0B, 4, 0);
    p0 = pulses; seq("1011011");
    chk("t2_pulses", pulses - p0, 1);
    chk("t2_cnt", cnt1, 1);
    do_reset();
    cfg(8'h03, 2, 1);
    p0 = pulses; seq("1111");
    chk("t3_pulses", pulses - p0, 3);
    chk("t3_cnt", cnt1, 3);
    do_reset();
    p0 = pulses; seq("10---11");
    chk("t4_pulses", pulses - p0, 1);
    chk("t4_cnt", cnt1, 1);
    do_reset();
    cfg(8'h0B, 0, 1);
    tick(0, 0);
    chk("t5_err_len0", err1, 1);
    p0 = pulses; seq("1011");
    chk("t5_no_pulse", pulses - p0, 0);
    cfg(8'h0B, 9, 1);
    tick(0, 0);
    chk("t5_err_len9", err1, 1);
    cfg(8'h0B, 4, 1);
    tick(0, 0);
    chk("t5_err_clear", err1, 0);
    p0 = pulses; seq("1011");
    chk("t5_pulse_after", pulses - p0, 1);
    do_reset();
    cfg(8'h03, 2, 1);
    seq("111111");
    chk("t6_cnt8", cnt1, 5);
    chk("t6_cnt2_sat", cnt2, 3);
    tick(1, 1);
    clr_count_i = 1;
    tick(0, 0);
    chk("t6_clr_seen", seen1, 1);
    chk("t6_clr_cnt", cnt1, 0);
    chk("t6_clr_cnt2", cnt2, 0);
    do_reset();
    for (int i = 0; i < 7; i++) tick(1, "1011101" >> (8 * (6 - i)) & 1);
    tick(0, 0);
    chk("t7_pre_cnt", cnt1, 1);
    #2 rst_ni = 0;
    #1;
    chk("t7_async_seen", seen1, 0);
    chk("t7_async_cnt", {cnt1, cnt2}, 0);
    chk("t7_async_err", err1, 0);
    tick(0, 0);
    rst_ni = 1;
    p0 = pulses;
    tick(1, 1);
    tick(0, 0);
    tick(0, 0);
    chk("t7_no_pulse", pulses - p0, 0);
    chk("t7_cnt", cnt1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
